// File: rtl/mc_port_responder.sv
// Single-port MC responder: services 8-byte RD/WR against a local word RAM and returns
// in-order responses LATENCY+1 cycles after accept; also answers write flushes.
module mc_port_responder #(
  parameter int RTNCTL_WIDTH = 32,
  parameter int MEM_AW       = 10,
  parameter int LATENCY      = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mc_rq_vld,
  input  logic [2:0]              mc_rq_cmd,
  input  logic [3:0]              mc_rq_scmd,
  input  logic [1:0]              mc_rq_size,
  input  logic [47:0]             mc_rq_vadr,
  input  logic [63:0]             mc_rq_data,
  input  logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
  output logic                    mc_rq_stall,
  input  logic                    mc_rq_flush,
  output logic                    mc_rs_flush_cmplt,
  output logic                    mc_rs_vld,
  output logic [2:0]              mc_rs_cmd,
  output logic [3:0]              mc_rs_scmd,
  output logic [63:0]             mc_rs_data,
  output logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
  input  logic                    mc_rs_stall,
  output logic                    err_ovfl,
  output logic                    err_unsup
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FA = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] STALL_C = CW'(FIFO_DEPTH - 2);

  typedef struct packed {
    logic                    is_wr;
    logic [RTNCTL_WIDTH-1:0] rtnctl;
    logic [63:0]             data;
  } rsp_t;

  typedef enum logic {FL_IDLE, FL_WAIT} fl_state_t;

  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] wr_out_q, wr_out_d;
  logic [CW-1:0] pend_q, pend_d;
  fl_state_t     state_q, state_d;
  logic          cmplt_q, cmplt_d;
  logic          stall_q;
  logic          err_ovfl_q, err_unsup_q;

  // ---------------- request decode and RAM ----------------
  logic              rq_sup, rq_acc, rq_wr, rq_drop;
  logic [MEM_AW-1:0] rq_idx;
  logic [63:0]       ram [2**MEM_AW];
  logic [63:0]       ram_rd;
  rsp_t              acc_ent;

  assign rq_sup  = ((mc_rq_cmd == 3'd1) || (mc_rq_cmd == 3'd2)) && (mc_rq_size == 2'd3);
  assign rq_drop = mc_rq_vld && rq_sup && (inflight_q == DEPTH_C);
  assign rq_acc  = mc_rq_vld && rq_sup && (inflight_q != DEPTH_C);
  assign rq_wr   = rq_acc && (mc_rq_cmd == 3'd2);
  assign rq_idx  = mc_rq_vadr[MEM_AW+2:3];
  assign ram_rd  = ram[rq_idx];

  always_ff @(posedge clk) begin
    if (rq_wr) ram[rq_idx] <= mc_rq_data;
  end

  always_comb begin
    acc_ent        = '0;
    acc_ent.is_wr  = (mc_rq_cmd == 3'd2);
    acc_ent.rtnctl = mc_rq_rtnctl;
    acc_ent.data   = (mc_rq_cmd == 3'd2) ? 64'd0 : ram_rd;
  end

  logic unused_bits;
  assign unused_bits = ^{mc_rq_scmd, mc_rq_vadr[47:MEM_AW+3], mc_rq_vadr[2:0]};

  // ---------------- fixed-latency delay line ----------------
  logic dl_vld_q [LATENCY];
  rsp_t dl_ent_q [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        dl_vld_q[i] <= 1'b0;
        dl_ent_q[i] <= '0;
      end
    end else begin
      dl_vld_q[0] <= rq_acc;
      dl_ent_q[0] <= acc_ent;
      for (int i = 1; i < LATENCY; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_ent_q[i] <= dl_ent_q[i-1];
      end
    end
  end

  // ---------------- response FIFO with empty bypass ----------------
  rsp_t          fifo_mem_q [FIFO_DEPTH];
  logic [FA:0]   fifo_wptr_q, fifo_rptr_q;
  logic          fifo_empty, fifo_push, fifo_pop;
  rsp_t          fifo_head, tail_ent, pop_ent;
  logic          tail_vld, pop;

  assign tail_vld   = dl_vld_q[LATENCY-1];
  assign tail_ent   = dl_ent_q[LATENCY-1];
  assign fifo_empty = (fifo_wptr_q == fifo_rptr_q);
  assign fifo_head  = fifo_mem_q[fifo_rptr_q[FA-1:0]];
  // When the FIFO is empty the delay-line tail goes straight to the output register,
  // which keeps the zero-occupancy latency at LATENCY+1.
  assign pop        = !mc_rs_stall && (tail_vld || !fifo_empty);
  assign pop_ent    = fifo_empty ? tail_ent : fifo_head;
  assign fifo_push  = tail_vld && !(pop && fifo_empty);
  assign fifo_pop   = pop && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wptr_q <= '0;
      fifo_rptr_q <= '0;
    end else begin
      if (fifo_push) fifo_wptr_q <= fifo_wptr_q + 1'b1;
      if (fifo_pop)  fifo_rptr_q <= fifo_rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem_q[fifo_wptr_q[FA-1:0]] <= tail_ent;
  end

  // ---------------- output register ----------------
  logic                    rs_vld_q, rs_is_wr_q, wr_cmp;
  logic [63:0]             rs_data_q;
  logic [RTNCTL_WIDTH-1:0] rs_rtnctl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_vld_q    <= 1'b0;
      rs_is_wr_q  <= 1'b0;
      rs_data_q   <= '0;
      rs_rtnctl_q <= '0;
    end else begin
      rs_vld_q    <= pop;
      rs_is_wr_q  <= pop && pop_ent.is_wr;
      rs_data_q   <= pop ? pop_ent.data : 64'd0;
      rs_rtnctl_q <= pop ? pop_ent.rtnctl : '0;
    end
  end

  assign wr_cmp = rs_vld_q && rs_is_wr_q;

  // ---------------- occupancy and outstanding-write counters ----------------
  always_comb begin
    inflight_d = inflight_q;
    if (rq_acc && !pop)
      inflight_d = inflight_q + 1'b1;
    else if (!rq_acc && pop && (inflight_q != '0))
      inflight_d = inflight_q - 1'b1;
  end

  always_comb begin
    wr_out_d = wr_out_q;
    if (rq_wr && !wr_cmp && (wr_out_q != DEPTH_C))
      wr_out_d = wr_out_q + 1'b1;
    else if (!rq_wr && wr_cmp && (wr_out_q != '0))
      wr_out_d = wr_out_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q  <= '0;
      wr_out_q    <= '0;
      stall_q     <= 1'b0;
      err_ovfl_q  <= 1'b0;
      err_unsup_q <= 1'b0;
    end else begin
      inflight_q  <= inflight_d;
      wr_out_q    <= wr_out_d;
      stall_q     <= (inflight_d >= STALL_C);
      err_ovfl_q  <= err_ovfl_q | rq_drop;
      err_unsup_q <= err_unsup_q | (mc_rq_vld && !rq_sup);
    end
  end

  // ---------------- flush FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FL_IDLE;
      pend_q  <= '0;
      cmplt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cmplt_q <= cmplt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      FL_IDLE: begin
        if (mc_rq_flush) begin
          pend_d = wr_out_d;
          if (wr_out_d != '0) state_d = FL_WAIT;
        end
      end
      FL_WAIT: begin
        // A repeated flush re-snapshots the outstanding writes; one completion covers both.
        if (mc_rq_flush)
          pend_d = wr_out_d;
        else if (wr_cmp && (pend_q != '0))
          pend_d = pend_q - 1'b1;
        if (pend_d == '0) state_d = FL_IDLE;
      end
      default: state_d = FL_IDLE;
    endcase
  end

  always_comb begin
    cmplt_d = 1'b0;
    case (state_q)
      FL_IDLE: cmplt_d = mc_rq_flush && (wr_out_d == '0);
      FL_WAIT: cmplt_d = (pend_d == '0);
      default: cmplt_d = 1'b0;
    endcase
  end

  // ---------------- outputs ----------------
  assign mc_rq_stall       = stall_q;
  assign mc_rs_flush_cmplt = cmplt_q;
  assign mc_rs_vld         = rs_vld_q;
  assign mc_rs_cmd         = rs_vld_q ? (rs_is_wr_q ? 3'd3 : 3'd2) : 3'd0;
  assign mc_rs_scmd        = 4'd0;
  assign mc_rs_data        = rs_data_q;
  assign mc_rs_rtnctl      = rs_rtnctl_q;
  assign err_ovfl          = err_ovfl_q;
  assign err_unsup         = err_unsup_q;

endmodule

// File: tb/tb_mc_port_responder.sv
// Directed bench for mc_port_responder: single-request vector table, then sequences for
// backpressure, overflow, flush completion, read-after-write and reset.
module tb_mc_port_responder;

  localparam int RTN_W = 32;
  localparam int NV    = 11;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mc_rq_vld;
  logic [2:0]       mc_rq_cmd;
  logic [3:0]       mc_rq_scmd;
  logic [1:0]       mc_rq_size;
  logic [47:0]      mc_rq_vadr;
  logic [63:0]      mc_rq_data;
  logic [RTN_W-1:0] mc_rq_rtnctl;
  logic             mc_rq_stall;
  logic             mc_rq_flush;
  logic             mc_rs_flush_cmplt;
  logic             mc_rs_vld;
  logic [2:0]       mc_rs_cmd;
  logic [3:0]       mc_rs_scmd;
  logic [63:0]      mc_rs_data;
  logic [RTN_W-1:0] mc_rs_rtnctl;
  logic             mc_rs_stall;
  logic             err_ovfl;
  logic             err_unsup;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mc_port_responder #(
    .RTNCTL_WIDTH(RTN_W), .MEM_AW(10), .LATENCY(4), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
    .mc_rq_size(mc_rq_size), .mc_rq_vadr(mc_rq_vadr), .mc_rq_data(mc_rq_data),
    .mc_rq_rtnctl(mc_rq_rtnctl), .mc_rq_stall(mc_rq_stall), .mc_rq_flush(mc_rq_flush),
    .mc_rs_flush_cmplt(mc_rs_flush_cmplt), .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd),
    .mc_rs_scmd(mc_rs_scmd), .mc_rs_data(mc_rs_data), .mc_rs_rtnctl(mc_rs_rtnctl),
    .mc_rs_stall(mc_rs_stall), .err_ovfl(err_ovfl), .err_unsup(err_unsup)
  );

  typedef struct {
    logic [2:0]  cmd;
    logic [1:0]  size;
    logic [47:0] vadr;
    logic [63:0] data;
    logic [31:0] rtn;
    logic        exp_vld;
    logic [2:0]  exp_cmd;
    logic [63:0] exp_data;
    logic        exp_unsup;
  } vec_t;

  vec_t vecs [NV];

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] cmd, input logic [1:0] size, input logic [47:0] vadr,
                       input logic [63:0] data, input logic [31:0] rtn);
    mc_rq_vld    = 1'b1;
    mc_rq_cmd    = cmd;
    mc_rq_size   = size;
    mc_rq_vadr   = vadr;
    mc_rq_data   = data;
    mc_rq_rtnctl = rtn;
    mc_rq_scmd   = 4'hF;
  endtask

  task automatic idle_rq();
    mc_rq_vld    = 1'b0;
    mc_rq_cmd    = 3'd0;
    mc_rq_size   = 2'd0;
    mc_rq_vadr   = '0;
    mc_rq_data   = '0;
    mc_rq_rtnctl = '0;
    mc_rq_scmd   = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic early;
    int   got, first, last, cnt, last_cmp, cmplt_at, n_cmplt;

    vecs[0]  = '{3'd2, 2'd3, 48'h40,           64'hDEADBEEF_CAFEF00D, 32'h11,       1'b1, 3'd3, 64'd0,                 1'b0};
    vecs[1]  = '{3'd1, 2'd3, 48'h40,           64'd0,                 32'h12,       1'b1, 3'd2, 64'hDEADBEEF_CAFEF00D, 1'b0};
    vecs[2]  = '{3'd2, 2'd3, 48'h0,            64'h5A,                32'h21,       1'b1, 3'd3, 64'd0,                 1'b0};
    vecs[3]  = '{3'd1, 2'd3, 48'h2000,         64'd0,                 32'h22,       1'b1, 3'd2, 64'h5A,                1'b0};
    vecs[4]  = '{3'd1, 2'd3, 48'h45,           64'd0,                 32'h23,       1'b1, 3'd2, 64'hDEADBEEF_CAFEF00D, 1'b0};
    vecs[5]  = '{3'd2, 2'd3, 48'h1FF8,         64'h01234567_89ABCDEF, 32'hAB,       1'b1, 3'd3, 64'd0,                 1'b0};
    vecs[6]  = '{3'd1, 2'd3, 48'hFFFF_0000_1FF8, 64'd0,               32'hFFFFFFFF, 1'b1, 3'd2, 64'h01234567_89ABCDEF, 1'b0};
    vecs[7]  = '{3'd7, 2'd3, 48'h40,           64'd0,                 32'h31,       1'b0, 3'd0, 64'd0,                 1'b1};
    vecs[8]  = '{3'd1, 2'd0, 48'h40,           64'd0,                 32'h32,       1'b0, 3'd0, 64'd0,                 1'b1};
    vecs[9]  = '{3'd2, 2'd2, 48'h40,           64'd0,                 32'h33,       1'b0, 3'd0, 64'd0,                 1'b1};
    vecs[10] = '{3'd1, 2'd3, 48'h40,           64'd0,                 32'h34,       1'b1, 3'd2, 64'hDEADBEEF_CAFEF00D, 1'b1};

    rst_n = 1'b0;
    idle_rq();
    mc_rq_flush = 1'b0;
    mc_rs_stall = 1'b0;
    cyc(); cyc();
    check("rst_rs_vld",   64'(mc_rs_vld),         64'd0);
    check("rst_rs_cmd",   64'(mc_rs_cmd),         64'd0);
    check("rst_rs_data",  mc_rs_data,             64'd0);
    check("rst_rs_rtn",   64'(mc_rs_rtnctl),      64'd0);
    check("rst_rq_stall", 64'(mc_rq_stall),       64'd0);
    check("rst_cmplt",    64'(mc_rs_flush_cmplt), 64'd0);
    check("rst_ovfl",     64'(err_ovfl),          64'd0);
    check("rst_unsup",    64'(err_unsup),         64'd0);
    rst_n = 1'b1;
    cyc(); cyc();

    // single requests: response expected exactly 5 cycles after issue
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].cmd, vecs[i].size, vecs[i].vadr, vecs[i].data, vecs[i].rtn);
      cyc();
      idle_rq();
      early = 1'b0;
      for (int c = 1; c < 5; c++) begin
        if (mc_rs_vld) early = 1'b1;
        cyc();
      end
      check($sformatf("v%0d_early", i), 64'(early), 64'd0);
      check($sformatf("v%0d_vld", i), 64'(mc_rs_vld), 64'(vecs[i].exp_vld));
      if (vecs[i].exp_vld) begin
        check($sformatf("v%0d_cmd", i),  64'(mc_rs_cmd),    64'(vecs[i].exp_cmd));
        check($sformatf("v%0d_data", i), mc_rs_data,        vecs[i].exp_data);
        check($sformatf("v%0d_rtn", i),  64'(mc_rs_rtnctl), 64'(vecs[i].rtn));
        check($sformatf("v%0d_scmd", i), 64'(mc_rs_scmd),   64'd0);
      end
      check($sformatf("v%0d_unsup", i), 64'(err_unsup), 64'(vecs[i].exp_unsup));
      cyc();
      check($sformatf("v%0d_onecyc", i), 64'(mc_rs_vld), 64'd0);
    end

    // 8 reads with the response side stalled, then drain
    mc_rs_stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(3'd1, 2'd3, 48'h40, 64'd0, 32'h100 + 32'(i));
      cyc();
      if (i == 4) check("bp_stall_after5", 64'(mc_rq_stall), 64'd0);
      if (i == 5) check("bp_stall_after6", 64'(mc_rq_stall), 64'd1);
    end
    idle_rq();
    early = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (mc_rs_vld) early = 1'b1;
      cyc();
    end
    check("bp_no_rsp_while_stalled", 64'(early), 64'd0);
    check("bp_ovfl", 64'(err_ovfl), 64'd0);
    mc_rs_stall = 1'b0;
    got = 0; first = -1; last = -1;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (mc_rs_vld) begin
        if (got < 8) check($sformatf("bp_rtn%0d", got), 64'(mc_rs_rtnctl), 64'h100 + 64'(got));
        if (got == 0) first = c;
        last = c;
        got++;
      end
    end
    check("bp_count", 64'(got), 64'd8);
    check("bp_b2b_span", 64'(last - first), 64'd7);
    check("bp_stall_clear", 64'(mc_rq_stall), 64'd0);

    // 9 reads ignoring mc_rq_stall: the 9th is dropped
    mc_rs_stall = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(3'd1, 2'd3, 48'h0, 64'd0, 32'h200 + 32'(i));
      cyc();
      if (i == 7) check("ov_ovfl_before", 64'(err_ovfl), 64'd0);
    end
    idle_rq();
    check("ov_ovfl_after", 64'(err_ovfl), 64'd1);
    repeat (4) cyc();
    mc_rs_stall = 1'b0;
    got = 0;
    for (int c = 0; c < 25; c++) begin
      cyc();
      if (mc_rs_vld) begin
        if (got < 9) check($sformatf("ov_rtn%0d", got), 64'(mc_rs_rtnctl), 64'h200 + 64'(got));
        got++;
      end
    end
    check("ov_count", 64'(got), 64'd8);

    // flush on an idle port
    mc_rq_flush = 1'b1;
    cyc();
    mc_rq_flush = 1'b0;
    check("fl_idle_cmplt", 64'(mc_rs_flush_cmplt), 64'd1);
    cyc();
    check("fl_idle_pulse", 64'(mc_rs_flush_cmplt), 64'd0);

    // three writes, flush with the third
    for (int i = 0; i < 3; i++) begin
      drive(3'd2, 2'd3, 48'h80 + 48'(8 * i), 64'h1000 + 64'(i), 32'h300 + 32'(i));
      mc_rq_flush = (i == 2);
      cyc();
    end
    idle_rq();
    mc_rq_flush = 1'b0;
    last_cmp = -1; cmplt_at = -1; n_cmplt = 0;
    for (int c = 3; c < 15; c++) begin
      if (mc_rs_vld && (mc_rs_cmd == 3'd3)) last_cmp = c;
      if (mc_rs_flush_cmplt) begin
        n_cmplt++;
        cmplt_at = c;
      end
      cyc();
    end
    check("fl_last_wrcmp", 64'(last_cmp), 64'd7);
    check("fl_cmplt_cycle", 64'(cmplt_at), 64'd8);
    check("fl_cmplt_count", 64'(n_cmplt), 64'd1);

    // read the cycle after a write to the same word
    drive(3'd2, 2'd3, 48'h88, 64'hA5A5_5A5A_0F0F_F0F0, 32'h3FF);
    cyc();
    drive(3'd1, 2'd3, 48'h88, 64'd0, 32'h400);
    cyc();
    idle_rq();
    repeat (4) cyc();
    check("raw_vld",  64'(mc_rs_vld),    64'd1);
    check("raw_cmd",  64'(mc_rs_cmd),    64'd2);
    check("raw_data", mc_rs_data,        64'hA5A5_5A5A_0F0F_F0F0);
    check("raw_rtn",  64'(mc_rs_rtnctl), 64'h400);

    // reset with requests in flight
    cyc();
    for (int i = 0; i < 4; i++) begin
      drive(3'd1, 2'd3, 48'h40, 64'd0, 32'h500 + 32'(i));
      cyc();
    end
    idle_rq();
    cyc();
    check("rs_pre_vld", 64'(mc_rs_vld),    64'd1);
    check("rs_pre_rtn", 64'(mc_rs_rtnctl), 64'h500);
    #2 rst_n = 1'b0;
    #1;
    check("rs_async_vld",   64'(mc_rs_vld),    64'd0);
    check("rs_async_data",  mc_rs_data,        64'd0);
    check("rs_async_rtn",   64'(mc_rs_rtnctl), 64'd0);
    check("rs_async_unsup", 64'(err_unsup),    64'd0);
    check("rs_async_ovfl",  64'(err_ovfl),     64'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      cyc();
      if (mc_rs_vld) cnt++;
    end
    check("rs_no_stale_rsp", 64'(cnt), 64'd0);
    drive(3'd1, 2'd3, 48'h40, 64'd0, 32'h600);
    cyc();
    idle_rq();
    repeat (4) cyc();
    check("rs_ram_vld",  64'(mc_rs_vld), 64'd1);
    check("rs_ram_data", mc_rs_data,     64'hDEADBEEF_CAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
